// File: rtl/data_memory_ctrl.sv
// Purpose : byte-addressable little-endian data memory with valid/ready requests and an init/preload sequence.
// Latency : response one cycle after accept; misaligned words respond two cycles after accept.
// Backpressure: req_ready low during init and for the one SPLIT cycle of a misaligned word.
//
// Ports:
//   clk, reset_n               clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_write/size/signed      store vs load, byte vs word, sign-extend byte loads
//   req_addr, req_wdata        byte address, store data (byte stores use [7:0])
//   rsp_valid/rdata/err        one-cycle response pulse, load data, out-of-range flag
//   init_done                  high once the array has been initialised
module data_memory_ctrl #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 1024,
   parameter bit PRELOAD = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);
   localparam int BYTES  = DATA_W / 8;
   localparam int WORDS  = DEPTH / BYTES;
   localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int LANE_W = $clog2(BYTES);
   localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SPLIT} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     init_idx_q, init_idx_d;
   logic                 req_ready_q, req_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 init_done_q, init_done_d;
   // Request context held across the SPLIT cycle
   logic                 sp_write_q, sp_write_d;
   logic [IDX_W-1:0]     sp_idx_q, sp_idx_d;
   logic [LANE_W-1:0]    sp_lane_q, sp_lane_d;
   logic [DATA_W-1:0]    sp_wdata_q, sp_wdata_d;
   logic [DATA_W-1:0]    sp_part_q, sp_part_d;

   logic [DATA_W-1:0]    mem_q [WORDS];
   logic [BYTES-1:0]     mem_we;
   logic [IDX_W-1:0]     mem_widx;
   logic [DATA_W-1:0]    mem_wdata;
   logic [IDX_W-1:0]     rd_idx;
   logic [DATA_W-1:0]    mem_rd;
   logic [DATA_W-1:0]    init_word;

   logic                 accept;
   logic [LANE_W-1:0]    req_lane;
   logic [IDX_W-1:0]     req_widx;
   logic [ADDR_W:0]      req_end;
   logic                 in_range;
   logic [7:0]           rd_byte;

   function automatic logic [7:0] init_byte(input int a);
      logic [7:0] b;
      b = 8'h00;
      if (PRELOAD) begin
         case (a)
            0: b = 8'h56;
            1: b = 8'h38;
            4: b = 8'h12;
            5: b = 8'h43;
            6: b = 8'hDE;
            7: b = 8'hBE;
            8: b = 8'hEF;
            9: b = 8'hAD;
            default: b = 8'h00;
         endcase
      end
      return b;
   endfunction

   assign accept   = req_valid && req_ready_q;
   assign req_lane = req_addr[LANE_W-1:0];
   assign req_widx = req_addr[LANE_W +: IDX_W];
   // One extra bit so addr + BYTES - 1 cannot wrap
   assign req_end  = {1'b0, req_addr} + (req_size ? (ADDR_W+1)'(BYTES - 1) : '0);
   assign in_range = (req_end <= LAST_ADDR);
   assign mem_rd   = mem_q[rd_idx];
   assign rd_byte  = mem_rd[8*req_lane +: 8];

   always_comb begin
      init_word = '0;
      for (int b = 0; b < BYTES; b++)
         init_word[8*b +: 8] = init_byte(int'(init_idx_q) * BYTES + b);
   end

   always_comb begin
      state_d     = state_q;
      init_idx_d  = init_idx_q;
      req_ready_d = req_ready_q;
      init_done_d = init_done_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      sp_write_d  = sp_write_q;
      sp_idx_d    = sp_idx_q;
      sp_lane_d   = sp_lane_q;
      sp_wdata_d  = sp_wdata_q;
      sp_part_d   = sp_part_q;
      mem_we      = '0;
      mem_widx    = req_widx;
      mem_wdata   = '0;
      rd_idx      = req_widx;

      case (state_q)
         ST_INIT: begin
            mem_we     = '1;
            mem_widx   = init_idx_q;
            mem_wdata  = init_word;
            init_idx_d = init_idx_q + IDX_W'(1);
            if (init_idx_q == IDX_W'(WORDS - 1)) begin
               state_d     = ST_IDLE;
               req_ready_d = 1'b1;
               init_done_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (accept) begin
               rsp_valid_d = 1'b1;
               if (!in_range) begin
                  rsp_err_d = 1'b1;
               end else if (!req_size) begin
                  if (req_write) begin
                     mem_we    = BYTES'(1) << req_lane;
                     mem_wdata = {BYTES{req_wdata[7:0]}};
                  end else begin
                     rsp_rdata_d = {{(DATA_W-8){req_signed & rd_byte[7]}}, rd_byte};
                  end
               end else if (req_lane == '0) begin
                  if (req_write) begin
                     mem_we    = '1;
                     mem_wdata = req_wdata;
                  end else begin
                     rsp_rdata_d = mem_rd;
                  end
               end else begin
                  // Misaligned word: upper lanes of word w now, lower lanes of w+1 next cycle
                  rsp_valid_d = 1'b0;
                  if (req_write) begin
                     mem_we    = {BYTES{1'b1}} << req_lane;
                     mem_wdata = req_wdata << (8*int'(req_lane));
                  end
                  sp_part_d   = mem_rd >> (8*int'(req_lane));
                  sp_write_d  = req_write;
                  sp_idx_d    = req_widx + IDX_W'(1);
                  sp_lane_d   = req_lane;
                  sp_wdata_d  = req_wdata;
                  state_d     = ST_SPLIT;
                  req_ready_d = 1'b0;
               end
            end
         end
         ST_SPLIT: begin
            rd_idx   = sp_idx_q;
            mem_widx = sp_idx_q;
            if (sp_write_q) begin
               mem_we    = ~({BYTES{1'b1}} << sp_lane_q);
               mem_wdata = sp_wdata_q >> (8*(BYTES - int'(sp_lane_q)));
            end else begin
               rsp_rdata_d = sp_part_q | (mem_rd << (8*(BYTES - int'(sp_lane_q))));
            end
            rsp_valid_d = 1'b1;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_INIT;
         init_idx_q  <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         init_done_q <= 1'b0;
         sp_write_q  <= 1'b0;
         sp_idx_q    <= '0;
         sp_lane_q   <= '0;
         sp_wdata_q  <= '0;
         sp_part_q   <= '0;
      end else begin
         state_q     <= state_d;
         init_idx_q  <= init_idx_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         init_done_q <= init_done_d;
         sp_write_q  <= sp_write_d;
         sp_idx_q    <= sp_idx_d;
         sp_lane_q   <= sp_lane_d;
         sp_wdata_q  <= sp_wdata_d;
         sp_part_q   <= sp_part_d;
      end
   end

   // Array has no reset; INIT rewrites every word
   always_ff @(posedge clk) begin
      for (int b = 0; b < BYTES; b++)
         if (mem_we[b])
            mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign init_done = init_done_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Purpose : self-checking bench for data_memory_ctrl (DATA_W=16, DEPTH=1024).
// Latency : n/a.
// Backpressure: requests wait on req_ready.
module tb_data_memory_ctrl;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic        req_size = 1'b0;
   logic        req_signed = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        init_done;

   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] ref_mem [DEPTH];

   data_memory_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference image after init: bytes 0..9 of the test image, zero elsewhere
   task automatic ref_init();
      logic [7:0] img [10];
      img = '{8'h56, 8'h38, 8'h00, 8'h00, 8'h12, 8'h43, 8'hDE, 8'hBE, 8'hEF, 8'hAD};
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i < 10) ? img[i] : 8'h00;
   endtask

   // Behavioural model of one request: byte array, little-endian, no wrap
   task automatic model(input logic w, input logic sz, input logic sg, input logic [15:0] a,
                        input logic [15:0] wd, output logic [15:0] rd, output logic err,
                        output logic split);
      int ai, nb;
      logic [7:0] b;
      ai = int'(a);
      nb = sz ? 2 : 1;
      rd = '0; err = 1'b0; split = 1'b0;
      if (ai + nb - 1 > DEPTH - 1) begin
         err = 1'b1;
      end else begin
         split = sz && (ai % 2 != 0);
         if (w) begin
            for (int i = 0; i < nb; i++) ref_mem[ai+i] = wd[8*i +: 8];
         end else if (sz) begin
            rd = {ref_mem[ai+1], ref_mem[ai]};
         end else begin
            b = ref_mem[ai];
            rd = sg ? {{8{b[7]}}, b} : {8'h00, b};
         end
      end
   endtask

   task automatic wait_init(input string tag);
      int cnt = 0;
      while (!init_done && cnt < 2000) begin
         @(posedge clk); #1;
         cnt++;
         if (cnt == 100) chk({tag, "_rdy_during_init"}, req_ready, 0);
      end
      chk({tag, "_init_cycles"}, cnt, 512);
      chk({tag, "_rdy_after_init"}, req_ready, 1);
   endtask

   // Issue one request, check it against the model, return the observed response
   task automatic do_req(input string tag, input logic w, input logic sz, input logic sg,
                         input logic [15:0] a, input logic [15:0] wd,
                         output logic [15:0] rd_o, output logic err_o);
      logic [15:0] e_rd;
      logic e_err, e_split, rdy_after;
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 2000) begin @(negedge clk); n++; end
      chk({tag, "_rdy_wait"}, n < 2000, 1);
      @(posedge clk); #1;
      model(w, sz, sg, a, wd, e_rd, e_err, e_split);
      rdy_after = req_ready;
      // Inputs scrambled after accept must not disturb the request
      req_valid = 1'b0;
      req_write = 1'($urandom); req_size = 1'($urandom); req_signed = 1'($urandom);
      req_addr = 16'($urandom); req_wdata = 16'($urandom);
      n = 1;
      while (!rsp_valid && n < 8) begin @(posedge clk); #1; n++; end
      chk({tag, "_lat"}, n, e_split ? 2 : 1);
      chk({tag, "_rdy_after"}, rdy_after, !e_split);
      chk({tag, "_rdata"}, rsp_rdata, e_rd);
      chk({tag, "_err"}, rsp_err, e_err);
      rd_o = rsp_rdata;
      err_o = rsp_err;
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {rsp_valid, rsp_err, rsp_rdata}, 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd, e_rd;
      logic er, e_err, e_sp;
      logic [15:0] b2b_addr [3];
      logic [15:0] b2b_exp [3];
      b2b_addr = '{16'h0000, 16'h0004, 16'h0006};
      b2b_exp  = '{16'h3856, 16'h4312, 16'hBEDE};

      // Reset state
      #1;
      chk("rst_state", {req_ready, rsp_valid, rsp_err, rsp_rdata, init_done}, 0);
      repeat (3) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      ref_init();
      wait_init("t1");

      do_req("t1_ld6", 0, 1, 0, 16'h0006, 0, rd, er); chk("t1_ld6_lit", rd, 16'hBEDE);
      do_req("t1_ld8", 0, 1, 0, 16'h0008, 0, rd, er); chk("t1_ld8_lit", rd, 16'hADEF);

      do_req("t2_b7s", 0, 0, 1, 16'h0007, 0, rd, er); chk("t2_b7s_lit", rd, 16'hFFBE);
      do_req("t2_b7u", 0, 0, 0, 16'h0007, 0, rd, er); chk("t2_b7u_lit", rd, 16'h00BE);
      do_req("t2_b4s", 0, 0, 1, 16'h0004, 0, rd, er); chk("t2_b4s_lit", rd, 16'h0012);

      do_req("t3_st11", 1, 1, 0, 16'h0011, 16'hA1B2, rd, er);
      do_req("t3_ld10", 0, 1, 0, 16'h0010, 0, rd, er); chk("t3_ld10_lit", rd, 16'hB200);
      do_req("t3_ld12", 0, 1, 0, 16'h0012, 0, rd, er); chk("t3_ld12_lit", rd, 16'h00A1);
      do_req("t3_ld11", 0, 1, 0, 16'h0011, 0, rd, er); chk("t3_ld11_lit", rd, 16'hA1B2);

      do_req("t4_ld3ff", 0, 1, 0, 16'h03FF, 0, rd, er); chk("t4_ld3ff_errlit", er, 1);
      do_req("t4_st400", 1, 0, 0, 16'h0400, 16'h00FF, rd, er); chk("t4_st400_errlit", er, 1);
      do_req("t4_ld3fe", 0, 1, 0, 16'h03FE, 0, rd, er);
      chk("t4_ld3fe_lit", {er, rd}, 17'h0_0000);

      // Back-to-back aligned loads
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 1'b1; req_signed = 1'b0;
      req_addr = b2b_addr[0];
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         model(0, 1, 0, b2b_addr[i], 0, e_rd, e_err, e_sp);
         if (i < 2) req_addr = b2b_addr[i+1];
         else req_valid = 1'b0;
         chk("t5_vld", rsp_valid, 1);
         chk("t5_rd_model", rsp_rdata, e_rd);
         chk("t5_rd_lit", rsp_rdata, b2b_exp[i]);
         chk("t5_rdy", req_ready, 1);
      end
      @(posedge clk); #1;
      chk("t5_end", rsp_valid, 0);

      // Randomized traffic against the model
      for (int k = 0; k < 300; k++) begin
         logic [15:0] a;
         case ($urandom_range(0, 3))
            0: a = 16'($urandom_range(0, 63));
            1: a = 16'($urandom_range(1000, 1040));
            2: a = 16'($urandom_range(0, 1023));
            default: a = 16'($urandom);
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_req("rnd", 1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), rd, er);
      end

      // Reset during the SPLIT cycle of a misaligned store
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 16'h0021;
      req_wdata = 16'h5A5A;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("t6_split_rdy", req_ready, 0);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_outs", {req_ready, rsp_valid, rsp_err, rsp_rdata, init_done}, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("t6_no_rsp", rsp_valid, 0);
      end
      @(negedge clk); reset_n = 1'b1;
      ref_init();
      wait_init("t6");
      do_req("t6_b21", 0, 0, 0, 16'h0021, 0, rd, er); chk("t6_b21_lit", rd, 16'h0000);
      do_req("t6_b22", 0, 0, 0, 16'h0022, 0, rd, er); chk("t6_b22_lit", rd, 16'h0000);
      do_req("t6_ld6", 0, 1, 0, 16'h0006, 0, rd, er); chk("t6_ld6_lit", rd, 16'hBEDE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
